tc_digital_io_ctrl: RTL and testbench
=====================================

Name: tc_digital_io_ctrl

Overview:
- Per-pad controller that sits directly between core logic and one bidirectional digital IO pad cell.
- Core-to-pad path: registers the output value, output enable, drive strength and pull configuration. Maps them to the pad's active-low OE and its pull-up/pull-down enables.
- Pad-to-core path: synchronises the asynchronous pad input, applies a runtime-programmable debounce filter, and produces clean level, rise and fall signals.

Parameters:
- SyncStages, 2, number of synchroniser flops on the pad input; legal range is ≥2.
- DebounceWidth, 8, width of the debounce threshold and of the debounce counter.
- InResetVal, 1'b0, reset value of the synchroniser flops and of the filtered level.

Ports:
- clk_i  input  1  block clock.
- rst_ni  input  1  asynchronous active-low reset.
- out_i  input  1  value to drive onto the pad.
- oe_i  input  1  output enable; 1 = drive the pad.
- drv_i  input  4  drive-strength code, passed through to the pad.
- pull_sel_i  input  2  pull select: 00 none, 01 pull-up, 10 pull-down, 11 none.
- debounce_i  input  DebounceWidth  stability threshold N in cycles; 0 = bypass.
- in_o  output  1  filtered pad level.
- rise_o  output  1  one-cycle pulse on a 0→1 change of in_o.
- fall_o  output  1  one-cycle pulse on a 1→0 change of in_o.
- pad_data_o  output  1  to pad cell data input.
- pad_oe_no  output  1  to pad cell active-low direction/OE.
- pad_drv_o  output  4  to pad cell drive strength.
- pad_pu_en_o  output  1  to pad cell pull-up enable.
- pad_pd_en_o  output  1  to pad cell pull-down enable.
- pad_data_i  input  1  from pad cell data output; asynchronous.

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous assert, active-low; all flops reset while it is low.
- Reset values:
  - pad_oe_no=1 (pad is input, never driven during reset).
  - pad_data_o=0, pad_drv_o=0, pad_pu_en_o=0, pad_pd_en_o=0.
  - Synchroniser chain = InResetVal, in_o = InResetVal, debounce counter = 0.
  - rise_o=0, fall_o=0.
- Output path:
  - Every pad_* output is registered; latency is 1 clock from the core input.
  - pad_oe_no <= ~oe_i.
  - pad_data_o <= out_i, registered regardless of oe_i.
  - pad_pu_en_o <= (pull_sel_i==01); pad_pd_en_o <= (pull_sel_i==10).
  - pad_pu_en_o and pad_pd_en_o are never both 1. Code 11 disables both.
- Synchroniser: pad_data_i passes through SyncStages flops. s denotes the last stage.
- Debounce filter:
  - Counter cnt, DebounceWidth bits, saturating.
  - If s==in_o: cnt <= 0.
  - If s!=in_o and (N==0 or cnt >= N-1): in_o <= s and cnt <= 0.
  - Otherwise: cnt <= cnt+1, saturating at all-ones.
  - N=0 and N=1 behave identically.
- Latency: a clean pad transition settled before edge k appears on in_o after edge k+SyncStages+max(N,1)-1. That is 3 edges for SyncStages=2, N≤1.
- Glitch rejection: a level held at s for fewer than max(N,1) consecutive cycles never reaches in_o. Any return to s==in_o clears cnt.
- N changed mid-count: the new N applies the next cycle. If cnt already ≥ new N-1 and s still differs, in_o updates on that edge.
- Edge pulses:
  - Registered; rise_o=1 exactly in the first cycle in_o is 1 after being 0.
  - fall_o likewise for 1→0.
  - Never both high; never high for more than 1 cycle per transition.
- Reset release: if the pad level differs from InResetVal, in_o settles after the normal latency and emits one rise/fall pulse. This is intended behaviour.
- Loopback: while oe_i=1 the pad input reflects the driven value, so in_o, rise_o and fall_o follow out_i through the full input latency. The block does not suppress this.
- Reset mid-operation: all state returns to reset values immediately. The pad is released (pad_oe_no=1) asynchronously.

Test Plan:
- Reset: rst_ni low, pad_data_i=1, oe_i=1 → pad_oe_no=1, pad_pu_en_o=0, pad_pd_en_o=0, in_o=0. After release with N=0: in_o=1 on the 3rd edge, with a rise_o pulse in that same cycle only.
- Output path: oe_i=1, out_i=1, drv_i=4'hA, pull_sel_i=01 → next cycle pad_oe_no=0, pad_data_o=1, pad_drv_o=A, pad_pu_en_o=1. Then pull_sel_i=11 → pad_pu_en_o=0, pad_pd_en_o=0.
- Debounce: N=4, pad steps 0→1 → in_o rises after edge 2+4=6 with one rise_o. Then a 3-cycle low glitch → no change on in_o, no fall_o.
- Threshold change: N=10, pad high for 5 cycles at s, then N=3 → in_o updates on the next edge.
- Async reset: assert rst_ni mid-debounce (cnt=7) and mid-drive (pad_oe_no=0) → pad_oe_no=1 without a clock edge. After release, cnt=0, no spurious pulses while pad_data_i equals InResetVal.

Source files
------------

// File: rtl/tc_digital_io_ctrl.sv
// Per-pad IO controller: registered core-to-pad drive/pull mapping, and a
// synchronised, debounced pad-to-core input with rise/fall edge pulses.
module tc_digital_io_ctrl #(
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned DebounceWidth = 8,
    parameter logic        InResetVal    = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     out_i,
    input  logic                     oe_i,
    input  logic [3:0]               drv_i,
    input  logic [1:0]               pull_sel_i,
    input  logic [DebounceWidth-1:0] debounce_i,
    output logic                     in_o,
    output logic                     rise_o,
    output logic                     fall_o,
    output logic                     pad_data_o,
    output logic                     pad_oe_no,
    output logic [3:0]               pad_drv_o,
    output logic                     pad_pu_en_o,
    output logic                     pad_pd_en_o,
    input  logic                     pad_data_i
);

    localparam int unsigned DrvWidth  = 4;
    localparam int unsigned PullWidth = 2;
    localparam logic [PullWidth-1:0] PullUp   = PullWidth'(2'b01);
    localparam logic [PullWidth-1:0] PullDown = PullWidth'(2'b10);

    logic                     r_pad_data;
    logic                     r_pad_oe_n;
    logic [DrvWidth-1:0]      r_pad_drv;
    logic                     r_pad_pu_en;
    logic                     r_pad_pd_en;

    logic [SyncStages-1:0]    r_sync;
    logic                     r_in;
    logic [DebounceWidth-1:0] r_cnt;
    logic                     r_rise;
    logic                     r_fall;

    logic                     w_s;
    logic [DebounceWidth-1:0] w_thr;
    logic                     w_in_nxt;
    logic [DebounceWidth-1:0] w_cnt_nxt;
    logic                     w_rise_nxt;
    logic                     w_fall_nxt;

    // Core-to-pad registers; reset leaves the pad undriven.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pad_data  <= 1'b0;
            r_pad_oe_n  <= 1'b1;
            r_pad_drv   <= '0;
            r_pad_pu_en <= 1'b0;
            r_pad_pd_en <= 1'b0;
        end else begin
            r_pad_data  <= out_i;
            r_pad_oe_n  <= ~oe_i;
            r_pad_drv   <= drv_i;
            r_pad_pu_en <= (pull_sel_i == PullUp);
            r_pad_pd_en <= (pull_sel_i == PullDown);
        end
    end

    assign w_s = r_sync[SyncStages-1];

    // Debounce next-state: accept the synchronised level once it has differed
    // from the filtered level for max(N,1) consecutive cycles.
    always_comb begin
        w_in_nxt   = r_in;
        w_cnt_nxt  = '0;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        w_thr      = (debounce_i == '0) ? '0 : DebounceWidth'(debounce_i - DebounceWidth'(1));
        if (w_s != r_in) begin
            if (r_cnt >= w_thr) begin
                w_in_nxt   = w_s;
                w_rise_nxt = w_s;
                w_fall_nxt = ~w_s;
            end else if (r_cnt != '1) begin
                w_cnt_nxt = r_cnt + DebounceWidth'(1);
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end
    end

    // Pad-to-core state: synchroniser chain, filter and edge pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= {SyncStages{InResetVal}};
            r_in   <= InResetVal;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], pad_data_i};
            r_in   <= w_in_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    assign pad_data_o  = r_pad_data;
    assign pad_oe_no   = r_pad_oe_n;
    assign pad_drv_o   = r_pad_drv;
    assign pad_pu_en_o = r_pad_pu_en;
    assign pad_pd_en_o = r_pad_pd_en;
    assign in_o        = r_in;
    assign rise_o      = r_rise;
    assign fall_o      = r_fall;

endmodule

// File: tb/tb_tc_digital_io_ctrl.sv
// Scoreboard bench for tc_digital_io_ctrl: stimulus pushes model predictions,
// an independent monitor pops and compares one entry per clock.
module tb_tc_digital_io_ctrl;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned DbW        = 8;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           out_i;
    logic           oe_i;
    logic [3:0]     drv_i;
    logic [1:0]     pull_sel_i;
    logic [DbW-1:0] debounce_i;
    logic           in_o;
    logic           rise_o;
    logic           fall_o;
    logic           pad_data_o;
    logic           pad_oe_no;
    logic [3:0]     pad_drv_o;
    logic           pad_pu_en_o;
    logic           pad_pd_en_o;
    logic           pad_data_i;

    tc_digital_io_ctrl #(
        .SyncStages   (SyncStages),
        .DebounceWidth(DbW),
        .InResetVal   (1'b0)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .out_i      (out_i),
        .oe_i       (oe_i),
        .drv_i      (drv_i),
        .pull_sel_i (pull_sel_i),
        .debounce_i (debounce_i),
        .in_o       (in_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .pad_data_o (pad_data_o),
        .pad_oe_no  (pad_oe_no),
        .pad_drv_o  (pad_drv_o),
        .pad_pu_en_o(pad_pu_en_o),
        .pad_pd_en_o(pad_pd_en_o),
        .pad_data_i (pad_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       in_v;
        logic       rise;
        logic       fall;
        logic       pdata;
        logic       poe_n;
        logic [3:0] drv;
        logic       pu;
        logic       pd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: delay line for the synchroniser, a run-length of
    // disagreeing samples for the filter.
    logic m_pipe[$];
    logic m_in;
    int   m_streak;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SyncStages; i++) m_pipe.push_back(1'b0);
        m_in     = 1'b0;
        m_streak = 0;
    endtask

    task automatic model_step();
        exp_t e;
        logic s;
        int   need;
        s       = m_pipe[0];
        need    = (debounce_i == 0) ? 1 : int'(debounce_i);
        e.rise  = 1'b0;
        e.fall  = 1'b0;
        if (s != m_in) begin
            m_streak++;
            if (m_streak >= need) begin
                m_in     = s;
                e.rise   = s;
                e.fall   = ~s;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
        void'(m_pipe.pop_front());
        m_pipe.push_back(pad_data_i);
        e.in_v  = m_in;
        e.pdata = out_i;
        e.poe_n = ~oe_i;
        e.drv   = drv_i;
        e.pu    = (pull_sel_i == 2'b01);
        e.pd    = (pull_sel_i == 2'b10);
        sb_q.push_back(e);
    endtask

    task automatic cycle(input logic pad, input logic out_v, input logic oe_v,
                         input logic [3:0] drv_v, input logic [1:0] pull_v,
                         input logic [DbW-1:0] n_v);
        @(negedge clk);
        pad_data_i = pad;
        out_i      = out_v;
        oe_i       = oe_v;
        drv_i      = drv_v;
        pull_sel_i = pull_v;
        debounce_i = n_v;
        model_step();
    endtask

    // Asserts reset between edges and checks the pad is released immediately.
    task automatic do_reset(input logic pad, input logic oe_v);
        @(posedge clk);
        #3;
        rst_ni     = 1'b0;
        pad_data_i = pad;
        oe_i       = oe_v;
        #1;
        chk("rst_pad_oe_n", 4'(pad_oe_no), 4'h1);
        chk("rst_pad_data", 4'(pad_data_o), 4'h0);
        chk("rst_pad_drv", pad_drv_o, 4'h0);
        chk("rst_pu", 4'(pad_pu_en_o), 4'h0);
        chk("rst_pd", 4'(pad_pd_en_o), 4'h0);
        chk("rst_in", 4'(in_o), 4'h0);
        chk("rst_rise", 4'(rise_o), 4'h0);
        chk("rst_fall", 4'(fall_o), 4'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_ni = 1'b1;
    endtask

    // Monitor: one scoreboard entry per clock while the DUT is running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("in_o", 4'(in_o), 4'(e.in_v));
                chk("rise_o", 4'(rise_o), 4'(e.rise));
                chk("fall_o", 4'(fall_o), 4'(e.fall));
                chk("pad_data_o", 4'(pad_data_o), 4'(e.pdata));
                chk("pad_oe_no", 4'(pad_oe_no), 4'(e.poe_n));
                chk("pad_drv_o", pad_drv_o, e.drv);
                chk("pad_pu_en_o", 4'(pad_pu_en_o), 4'(e.pu));
                chk("pad_pd_en_o", 4'(pad_pd_en_o), 4'(e.pd));
            end
        end
    end

    initial begin
        int             len;
        logic           pad_v;
        logic           out_v;
        logic           oe_v;
        logic [DbW-1:0] n_v;

        rst_ni     = 1'b0;
        out_i      = 1'b0;
        oe_i       = 1'b0;
        drv_i      = 4'h0;
        pull_sel_i = 2'b00;
        debounce_i = '0;
        pad_data_i = 1'b0;
        model_reset();

        // Reset with pad high and OE requested; release with N=0.
        do_reset(1'b1, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'd0);

        // Output path and pull mapping.
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 4'hA, 2'b01, 8'd0);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 4'hA, 2'b11, 8'd0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 4'h5, 2'b10, 8'd1);

        // Debounce N=4: step to high, then a 3-cycle low glitch.
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 8'd0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'd4);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 8'd4);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'd4);

        // Threshold lowered mid-count.
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 8'd0);
        repeat (7) cycle(1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'd10);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'd3);

        // Async reset mid-debounce while driving.
        repeat (9) cycle(1'b0, 1'b0, 1'b1, 4'h3, 2'b01, 8'd20);
        do_reset(1'b0, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 8'd0);

        // Randomised runs, with loopback whenever the pad is driven.
        for (int i = 0; i < 80; i++) begin
            n_v   = DbW'($urandom_range(0, 6));
            len   = $urandom_range(1, 9);
            pad_v = 1'($urandom_range(0, 1));
            out_v = 1'($urandom_range(0, 1));
            oe_v  = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                cycle(oe_v ? out_v : pad_v, out_v, oe_v,
                      4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), n_v);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 4'(sb_q.size()), 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
